vidscanout: RTL and testbench
=============================

Name: vidscanout

Overview:
- Reads the 160x144 2-bit framebuffer that the LCD capture path writes into VRAM.
- Generates standard display timing and scales the image by an integer factor, centred in the active area with a border colour.
- Produces pixel data, DE, HSYNC and VSYNC for the downstream palette/encoder stage.
- It is the read side of the VRAM and uses the same {ypos[7:0], xpos[7:0]} address layout as the capture side.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch, in clocks
- H_SYNC, 96, horizontal sync width, in clocks
- H_BP, 48, horizontal back porch, in clocks
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines
- IMG_W, 160, source image width
- IMG_H, 144, source image height
- SCALE, 3, integer upscale factor in both axes
- SYNC_POL, 0, sync active level (0 = active-low)
- BORDER, 2'b00, pixel value output outside the image

Ports:
- vid_clk  in  1  pixel clock; the only clock
- rst_n  in  1  asynchronous reset, active-low
- vramclk  out  1  equals vid_clk
- vramaddr  out  16  [15:8] = image row, [7:0] = image column
- vramre  out  1  read enable, high when vramaddr is valid
- vramdata  in  2  synchronous VRAM read data, valid one clock after vramaddr/vramre
- out_de  out  1  active video
- out_hsync  out  1  horizontal sync at SYNC_POL
- out_vsync  out  1  vertical sync at SYNC_POL
- out_data  out  2  pixel value; 0 when out_de is low
- frame_start  out  1  one-clock pulse aligned with the first active pixel of a frame

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - H_OFF = (H_ACTIVE - IMG_W*SCALE)/2; V_OFF = (V_ACTIVE - IMG_H*SCALE)/2.
  - Defaults give 800x525, H_OFF = 80, V_OFF = 24.
  - Parameter sets with IMG_W*SCALE > H_ACTIVE or IMG_H*SCALE > V_ACTIVE are illegal and must be flagged at elaboration.
- Counters:
  - hcnt runs 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments on each hcnt wrap, runs 0..V_TOTAL-1 and wraps.
  - Active region is hcnt < H_ACTIVE and vcnt < V_ACTIVE.
  - HSYNC is asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; VSYNC uses the same rule on vcnt.
- Scaling uses no divider:
  - xsub counts 0..SCALE-1; xpos increments when xsub wraps.
  - xsub and xpos are cleared to 0 when hcnt = H_OFF-1 (or on line wrap when H_OFF = 0).
  - ysub and ypos work the same way, advancing once per line at hcnt wrap while V_OFF <= vcnt < V_OFF+IMG_H*SCALE.
  - ysub and ypos are cleared at the start of each frame.
- in_img = active AND H_OFF <= hcnt < H_OFF+IMG_W*SCALE AND V_OFF <= vcnt < V_OFF+IMG_H*SCALE.
- Pipeline, fixed latency 2 from counter state at clock t:
  - t+1: vramaddr = {ypos, xpos} and vramre = in_img, both registered. When vramre is low, vramaddr holds its last value.
  - t+2: out_de, out_hsync, out_vsync and frame_start reflect the state at t.
  - t+2: out_data = vramdata if the delayed in_img is high, else BORDER if the delayed active is high, else 0.
- frame_start is high for one clock: the t+2 output for hcnt = 0, vcnt = 0.
- Reset while rst_n is low, asynchronous:
  - hcnt, vcnt, sub-counters, xpos and ypos are 0.
  - vramaddr = 0, vramre = 0, out_de = 0, out_data = 0, frame_start = 0.
  - out_hsync and out_vsync are at their inactive level (!SYNC_POL).
  - Pipeline registers are cleared.
- After rst_n deasserts, the first output clock reports hcnt = 0, vcnt = 0 state two clocks later; the first frame_start follows the same rule.
- Reset asserted mid-frame aborts the frame immediately; outputs return to the reset values above.
- vramaddr never exceeds {IMG_H-1, IMG_W-1} while vramre is high.
- xpos and ypos never reach IMG_W or IMG_H inside the image.

Test Plan:
- Reset release, defaults: count 800 clocks between HSYNC falling edges and 525 lines between VSYNC falling edges; HSYNC is low for 96 clocks starting at hcnt 656; frame_start pulses once per 420000 clocks.
- VRAM model with data = (x+y)&3, 1-clock read latency: line vcnt = 24 gives out_data = BORDER for active pixels 0..79, then a value sequence of 0,0,0,1,1,1,2,... (each column repeated 3 times), then BORDER from active pixel 560; out_de is high for 640 clocks per line.
- Address trace: vramre is high for exactly 480 clocks per image line; vramaddr goes 0x0000 (x3), 0x0001 (x3) ... 0x009F; rows advance every 3 lines; the last address in the frame is 0x8F9F; vramre is low for lines 0..23 and 456..479.
- Alignment: out_de rises exactly 2 clocks after hcnt = 0 at vcnt = 0; out_data is 0 whenever out_de is low.
- Reset mid-line at hcnt 300, vcnt 100: all outputs reach reset values while rst_n is low, without a clock edge; after release the timing restarts from hcnt 0, vcnt 0.
- SCALE = 2, SYNC_POL = 1: H_OFF = 160, V_OFF = 96; syncs idle low and pulse high; each column is repeated 2 times and each row for 2 lines.

Source files
------------

// File: rtl/vidscanout.sv
// VRAM scan-out: display timing generator with integer upscaling of a 2-bit framebuffer.
// VRAM reads and the matching sync/DE/data outputs are two clocks behind the raster counters.
module vidscanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned IMG_W    = 160,
  parameter int unsigned IMG_H    = 144,
  parameter int unsigned SCALE    = 3,
  parameter bit          SYNC_POL = 1'b0,
  parameter logic [1:0]  BORDER   = 2'b00
) (
  input  logic        vid_clk,
  input  logic        rst_n,
  output logic        vramclk,
  output logic [15:0] vramaddr,
  output logic        vramre,
  input  logic [1:0]  vramdata,
  output logic        out_de,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic [1:0]  out_data,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned IMG_WS  = IMG_W * SCALE;
  localparam int unsigned IMG_HS  = IMG_H * SCALE;
  localparam int unsigned H_OFF   = (H_ACTIVE >= IMG_WS) ? (H_ACTIVE - IMG_WS) / 2 : 0;
  localparam int unsigned V_OFF   = (V_ACTIVE >= IMG_HS) ? (V_ACTIVE - IMG_HS) / 2 : 0;
  // Column counters are cleared one clock before the image window opens.
  localparam int unsigned H_CLR   = (H_OFF == 0) ? H_TOTAL - 1 : H_OFF - 1;
  localparam int unsigned HW      = $clog2(H_TOTAL + 1);
  localparam int unsigned VW      = $clog2(V_TOTAL + 1);
  localparam int unsigned SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  if (IMG_W * SCALE > H_ACTIVE) begin : g_bad_width
    $error("vidscanout: IMG_W*SCALE exceeds H_ACTIVE");
  end
  if (IMG_H * SCALE > V_ACTIVE) begin : g_bad_height
    $error("vidscanout: IMG_H*SCALE exceeds V_ACTIVE");
  end
  if (SCALE < 1 || IMG_W > 256 || IMG_H > 256) begin : g_bad_geometry
    $error("vidscanout: SCALE must be >= 1 and the image must fit 8-bit coordinates");
  end

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [SW-1:0] xsub, ysub;
  logic [7:0]    xpos, ypos;

  logic h_wrap, v_wrap, h_act, v_act, h_win, v_win;
  logic hs_raw, vs_raw, in_img, active, first_px;

  // Stage 1 / stage 2 pipeline state
  logic p1_act, p1_img, p1_hs, p1_vs, p1_fs;
  logic p2_img;

  assign vramclk = vid_clk;

  always_comb begin
    h_wrap   = (hcnt == HW'(H_TOTAL - 1));
    v_wrap   = (vcnt == VW'(V_TOTAL - 1));
    h_act    = (hcnt < HW'(H_ACTIVE));
    v_act    = (vcnt < VW'(V_ACTIVE));
    h_win    = (hcnt >= HW'(H_OFF)) && (hcnt < HW'(H_OFF + IMG_WS));
    v_win    = (vcnt >= VW'(V_OFF)) && (vcnt < VW'(V_OFF + IMG_HS));
    hs_raw   = (hcnt >= HW'(H_ACTIVE + H_FP)) && (hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs_raw   = (vcnt >= VW'(V_ACTIVE + V_FP)) && (vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    active   = h_act && v_act;
    in_img   = active && h_win && v_win;
    first_px = (hcnt == '0) && (vcnt == '0);
  end

  always_ff @(posedge vid_clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_wrap) begin
      hcnt <= '0;
      vcnt <= v_wrap ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Horizontal scaling: each source column is held for SCALE clocks.
  always_ff @(posedge vid_clk or negedge rst_n) begin
    if (!rst_n) begin
      xsub <= '0;
      xpos <= '0;
    end else if (hcnt == HW'(H_CLR)) begin
      xsub <= '0;
      xpos <= '0;
    end else if (h_win) begin
      if (xsub == SW'(SCALE - 1)) begin
        xsub <= '0;
        xpos <= xpos + 8'd1;
      end else begin
        xsub <= xsub + SW'(1);
      end
    end
  end

  // Vertical scaling: each source row is held for SCALE lines.
  always_ff @(posedge vid_clk or negedge rst_n) begin
    if (!rst_n) begin
      ysub <= '0;
      ypos <= '0;
    end else if (h_wrap) begin
      if (v_wrap) begin
        ysub <= '0;
        ypos <= '0;
      end else if (v_win) begin
        if (ysub == SW'(SCALE - 1)) begin
          ysub <= '0;
          ypos <= ypos + 8'd1;
        end else begin
          ysub <= ysub + SW'(1);
        end
      end
    end
  end

  // Stage 1: VRAM request plus delayed raster flags.
  always_ff @(posedge vid_clk or negedge rst_n) begin
    if (!rst_n) begin
      vramaddr <= '0;
      vramre   <= 1'b0;
      p1_act   <= 1'b0;
      p1_img   <= 1'b0;
      p1_hs    <= ~SYNC_POL;
      p1_vs    <= ~SYNC_POL;
      p1_fs    <= 1'b0;
    end else begin
      if (in_img) begin
        vramaddr <= {ypos, xpos};
      end
      vramre <= in_img;
      p1_act <= active;
      p1_img <= in_img;
      p1_hs  <= SYNC_POL ? hs_raw : ~hs_raw;
      p1_vs  <= SYNC_POL ? vs_raw : ~vs_raw;
      p1_fs  <= first_px;
    end
  end

  // Stage 2: outputs line up with the VRAM read data for the same pixel.
  always_ff @(posedge vid_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_de      <= 1'b0;
      out_hsync   <= ~SYNC_POL;
      out_vsync   <= ~SYNC_POL;
      frame_start <= 1'b0;
      p2_img      <= 1'b0;
    end else begin
      out_de      <= p1_act;
      out_hsync   <= p1_hs;
      out_vsync   <= p1_vs;
      frame_start <= p1_fs;
      p2_img      <= p1_img;
    end
  end

  // vramdata is only valid during the cycle after the request, so it is muxed, not registered.
  always_comb begin
    out_data = 2'b00;
    if (p2_img) begin
      out_data = vramdata;
    end else if (out_de) begin
      out_data = BORDER;
    end
  end

endmodule

// File: tb/tb_vidscanout.sv
// Bench for vidscanout: a default-timing instance and a small SCALE=2 active-high-sync instance,
// each fed by a 1-clock-latency VRAM returning (x+y)&3.
module tb_vidscanout;

  localparam int NA = 21700;
  localparam int NB = 700;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic        vclk_a, re_a, de_a, hs_a, vs_a, fs_a;
  logic [15:0] addr_a;
  logic [1:0]  vdata_a, data_a;
  logic        vclk_b, re_b, de_b, hs_b, vs_b, fs_b;
  logic [15:0] addr_b;
  logic [1:0]  vdata_b, data_b;

  vidscanout u_a (
    .vid_clk(clk), .rst_n(rst_a), .vramclk(vclk_a), .vramaddr(addr_a), .vramre(re_a),
    .vramdata(vdata_a), .out_de(de_a), .out_hsync(hs_a), .out_vsync(vs_a), .out_data(data_a),
    .frame_start(fs_a)
  );

  vidscanout #(
    .H_ACTIVE(24), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(16), .V_FP(1), .V_SYNC(2),
    .V_BP(1), .IMG_W(8), .IMG_H(6), .SCALE(2), .SYNC_POL(1'b1), .BORDER(2'b10)
  ) u_b (
    .vid_clk(clk), .rst_n(rst_b), .vramclk(vclk_b), .vramaddr(addr_b), .vramre(re_b),
    .vramdata(vdata_b), .out_de(de_b), .out_hsync(hs_b), .out_vsync(vs_b), .out_data(data_b),
    .frame_start(fs_b)
  );

  always @(posedge clk) begin
    vdata_a <= 2'(addr_a[7:0] + addr_a[15:8]);
    vdata_b <= 2'(addr_b[7:0] + addr_b[15:8]);
  end

  typedef struct packed {
    logic de, hs, vs, fs, re;
    logic [1:0]  data;
    logic [15:0] addr;
  } samp_t;

  typedef struct {
    int h, v;
    logic de, hs, vs, fs;
    logic [1:0]  data;
    logic re;
    logic [15:0] addr;
  } vec_t;

  samp_t sa [0:NA];
  samp_t sb [0:NB];
  int na, nb;
  int checks = 0;
  int errors = 0;

  // Edge counters since reset release; sample n holds outputs after the n-th clock edge.
  always @(posedge clk) begin
    if (!rst_a) na <= 0; else na <= na + 1;
    if (!rst_b) nb <= 0; else nb <= nb + 1;
  end

  always @(negedge clk) begin
    if (rst_a && na <= NA) sa[na] <= {de_a, hs_a, vs_a, fs_a, re_a, data_a, addr_a};
    if (rst_b && nb <= NB) sb[nb] <= {de_b, hs_b, vs_b, fs_b, re_b, data_b, addr_b};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int h, input int v, input logic de, input logic hs,
                              input logic vs, input logic fs, input logic [1:0] d,
                              input logic re, input logic [15:0] a);
    vec_t r;
    r.h = h; r.v = v; r.de = de; r.hs = hs; r.vs = vs; r.fs = fs;
    r.data = d; r.re = re; r.addr = a;
    return r;
  endfunction

  // so = outputs two edges after the raster position, sr = VRAM request one edge after.
  task automatic check_vec(input string tag, input vec_t v, input samp_t so, input samp_t sr);
    string p;
    p = $sformatf("%s(h%0d,v%0d)", tag, v.h, v.v);
    chk({p, " de"}, so.de, v.de);
    chk({p, " hsync"}, so.hs, v.hs);
    chk({p, " vsync"}, so.vs, v.vs);
    chk({p, " frame_start"}, so.fs, v.fs);
    chk({p, " data"}, so.data, v.data);
    chk({p, " vramre"}, sr.re, v.re);
    if (v.re) chk({p, " vramaddr"}, sr.addr, v.addr);
  endtask

  task automatic chk_reset(input string tag, input logic de, input logic hs, input logic vs,
                           input logic fs, input logic re, input logic [1:0] d,
                           input logic [15:0] a, input logic idle);
    chk({tag, " rst de"}, de, 1'b0);
    chk({tag, " rst hsync"}, hs, idle);
    chk({tag, " rst vsync"}, vs, idle);
    chk({tag, " rst frame_start"}, fs, 1'b0);
    chk({tag, " rst vramre"}, re, 1'b0);
    chk({tag, " rst data"}, d, 2'b00);
    chk({tag, " rst vramaddr"}, a, 16'h0000);
  endtask

  vec_t va[$];
  vec_t vb[$];

  initial begin
    int idx, cnt, cnt2, fall1, fall2, rise1;

    // Default timing: 800x525, image window h 80..559, v 24..455, active-low syncs.
    va.push_back(mk(0,   0,  1, 1, 1, 1, 2'd0, 0, 16'h0000));
    va.push_back(mk(1,   0,  1, 1, 1, 0, 2'd0, 0, 16'h0000));
    va.push_back(mk(639, 0,  1, 1, 1, 0, 2'd0, 0, 16'h0000));
    va.push_back(mk(640, 0,  0, 1, 1, 0, 2'd0, 0, 16'h0000));
    va.push_back(mk(655, 0,  0, 1, 1, 0, 2'd0, 0, 16'h0000));
    va.push_back(mk(656, 0,  0, 0, 1, 0, 2'd0, 0, 16'h0000));
    va.push_back(mk(751, 0,  0, 0, 1, 0, 2'd0, 0, 16'h0000));
    va.push_back(mk(752, 0,  0, 1, 1, 0, 2'd0, 0, 16'h0000));
    va.push_back(mk(300, 23, 1, 1, 1, 0, 2'd0, 0, 16'h0000));
    va.push_back(mk(79,  24, 1, 1, 1, 0, 2'd0, 0, 16'h0000));
    va.push_back(mk(80,  24, 1, 1, 1, 0, 2'd0, 1, 16'h0000));
    va.push_back(mk(83,  24, 1, 1, 1, 0, 2'd1, 1, 16'h0001));
    va.push_back(mk(86,  24, 1, 1, 1, 0, 2'd2, 1, 16'h0002));
    va.push_back(mk(89,  24, 1, 1, 1, 0, 2'd3, 1, 16'h0003));
    va.push_back(mk(92,  24, 1, 1, 1, 0, 2'd0, 1, 16'h0004));
    va.push_back(mk(559, 24, 1, 1, 1, 0, 2'd3, 1, 16'h009F));
    va.push_back(mk(560, 24, 1, 1, 1, 0, 2'd0, 0, 16'h0000));
    va.push_back(mk(700, 24, 0, 0, 1, 0, 2'd0, 0, 16'h0000));
    va.push_back(mk(80,  26, 1, 1, 1, 0, 2'd0, 1, 16'h0000));
    va.push_back(mk(80,  27, 1, 1, 1, 0, 2'd1, 1, 16'h0100));
    va.push_back(mk(83,  27, 1, 1, 1, 0, 2'd2, 1, 16'h0101));

    // Small timing: 32x20, image window h 4..19, v 2..13, active-high syncs, BORDER=2.
    vb.push_back(mk(0,  0,  1, 0, 0, 1, 2'd2, 0, 16'h0000));
    vb.push_back(mk(25, 0,  0, 0, 0, 0, 2'd0, 0, 16'h0000));
    vb.push_back(mk(26, 0,  0, 1, 0, 0, 2'd0, 0, 16'h0000));
    vb.push_back(mk(28, 0,  0, 1, 0, 0, 2'd0, 0, 16'h0000));
    vb.push_back(mk(29, 0,  0, 0, 0, 0, 2'd0, 0, 16'h0000));
    vb.push_back(mk(3,  2,  1, 0, 0, 0, 2'd2, 0, 16'h0000));
    vb.push_back(mk(4,  2,  1, 0, 0, 0, 2'd0, 1, 16'h0000));
    vb.push_back(mk(5,  2,  1, 0, 0, 0, 2'd0, 1, 16'h0000));
    vb.push_back(mk(6,  2,  1, 0, 0, 0, 2'd1, 1, 16'h0001));
    vb.push_back(mk(19, 2,  1, 0, 0, 0, 2'd3, 1, 16'h0007));
    vb.push_back(mk(20, 2,  1, 0, 0, 0, 2'd2, 0, 16'h0000));
    vb.push_back(mk(4,  3,  1, 0, 0, 0, 2'd0, 1, 16'h0000));
    vb.push_back(mk(4,  4,  1, 0, 0, 0, 2'd1, 1, 16'h0100));
    vb.push_back(mk(7,  5,  1, 0, 0, 0, 2'd2, 1, 16'h0101));
    vb.push_back(mk(19, 13, 1, 0, 0, 0, 2'd0, 1, 16'h0507));
    vb.push_back(mk(4,  14, 1, 0, 0, 0, 2'd2, 0, 16'h0000));
    vb.push_back(mk(0,  15, 1, 0, 0, 0, 2'd2, 0, 16'h0000));
    vb.push_back(mk(0,  16, 0, 0, 0, 0, 2'd0, 0, 16'h0000));
    vb.push_back(mk(0,  17, 0, 0, 1, 0, 2'd0, 0, 16'h0000));
    vb.push_back(mk(31, 18, 0, 0, 1, 0, 2'd0, 0, 16'h0000));
    vb.push_back(mk(0,  19, 0, 0, 0, 0, 2'd0, 0, 16'h0000));
    vb.push_back(mk(0,  20, 1, 0, 0, 1, 2'd2, 0, 16'h0000));
    vb.push_back(mk(1,  20, 1, 0, 0, 0, 2'd2, 0, 16'h0000));

    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    chk_reset("A async", de_a, hs_a, vs_a, fs_a, re_a, data_a, addr_a, 1'b1);
    repeat (3) @(negedge clk);
    chk_reset("A", de_a, hs_a, vs_a, fs_a, re_a, data_a, addr_a, 1'b1);
    chk_reset("B", de_b, hs_b, vs_b, fs_b, re_b, data_b, addr_b, 1'b0);

    // ---- default instance ----
    rst_a = 1'b1;
    while (na < NA + 2) @(negedge clk);

    chk("A first clock de", sa[1].de, 1'b0);
    chk("A first clock frame_start", sa[1].fs, 1'b0);
    foreach (va[i]) begin
      idx = va[i].v * 800 + va[i].h;
      check_vec("A", va[i], sa[idx + 2], sa[idx + 1]);
    end

    fall1 = -1; fall2 = -1; rise1 = -1;
    for (int n = 3; n <= NA; n++) begin
      if (sa[n-1].hs && !sa[n].hs) begin
        if (fall1 < 0) fall1 = n; else if (fall2 < 0) fall2 = n;
      end
      if (!sa[n-1].hs && sa[n].hs && fall1 >= 0 && rise1 < 0) rise1 = n;
    end
    chk("A hsync first fall edge", fall1, 658);
    chk("A hsync period", fall2 - fall1, 800);
    chk("A hsync low width", rise1 - fall1, 96);

    cnt = 0; cnt2 = 0;
    for (int n = 1; n <= NA; n++) begin
      if (!sa[n].de && sa[n].data != 2'b00) cnt++;
      if (sa[n].fs) cnt2++;
    end
    chk("A data zero while de low (violations)", cnt, 0);
    chk("A frame_start pulses", cnt2, 1);

    cnt = 0; cnt2 = 0;
    for (int n = 1; n <= 19200; n++) if (sa[n].re) cnt++;
    for (int n = 19201; n <= 20000; n++) if (sa[n].re) cnt2++;
    chk("A vramre clocks lines 0..23", cnt, 0);
    chk("A vramre clocks line 24", cnt2, 480);

    cnt = 0;
    for (int h = 80; h <= 559; h++) begin
      if (sa[19200 + h + 1].addr !== {8'h00, 8'((h - 80) / 3)}) cnt++;
    end
    chk("A line 24 address trace (mismatches)", cnt, 0);
    rst_a = 1'b0;

    // ---- small instance ----
    rst_b = 1'b1;
    while (nb < NB + 2) @(negedge clk);
    foreach (vb[i]) begin
      idx = vb[i].v * 32 + vb[i].h;
      check_vec("B", vb[i], sb[idx + 2], sb[idx + 1]);
    end
    cnt = 0;
    for (int n = 1; n <= NB; n++) if (sb[n].fs) cnt++;
    chk("B frame_start pulses", cnt, 2);

    // Mid-frame reset: outputs for raster (10,5) of frame 2 are on the wire at edge 812.
    while (nb < 812) @(negedge clk);
    chk("B pre-reset de", de_b, 1'b1);
    chk("B pre-reset vramre", re_b, 1'b1);
    #2 rst_b = 1'b0;
    #1;
    chk_reset("B mid-frame", de_b, hs_b, vs_b, fs_b, re_b, data_b, addr_b, 1'b0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    while (nb < 75) @(negedge clk);
    chk("B restart clock1 de", sb[1].de, 1'b0);
    chk("B restart clock2 de", sb[2].de, 1'b1);
    chk("B restart frame_start", sb[2].fs, 1'b1);
    chk("B restart border data", sb[2].data, 2'd2);
    chk("B restart vramre (h4,v2)", sb[69].re, 1'b1);
    chk("B restart vramaddr (h4,v2)", sb[69].addr, 16'h0000);
    chk("B restart data (h4,v2)", sb[70].data, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
